// File: rtl/rv32i_lsu_pkg.sv
// rtl/rv32i_lsu_pkg.sv - funct3 encodings and FSM states for the RV32I load/store unit
package rv32i_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/rv32i_lsu_load_align.sv
// rtl/rv32i_lsu_load_align.sv - load byte/half extraction with sign or zero extension
module lsu_load_align
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - RV32I load/store unit bridging execute stage and native memory port
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    input  logic              req_store_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [XLEN-1:0]   req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              stall_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              done_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic [XLEN-1:0]   fault_addr_o
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state, state_nx;
    logic [XLEN-1:0]   addr_q, wdata_q, wb_data_q, fault_addr_q, ld_data, st_wdata;
    logic [XLEN/8-1:0] wstrb_q, st_wstrb;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              store_q, misaligned_q;
    logic [31:0]       tmo_cnt;
    logic              fault, accept, go, tmo_hit;

    // Fault detection and store lane steering from the raw request
    always_comb begin
        fault    = 1'b0;
        st_wdata = '0;
        st_wstrb = '0;
        if (req_store_i) begin
            case (req_funct3_i)
                F3_SB: begin
                    st_wdata = {4{req_wdata_i[7:0]}};
                    st_wstrb = 4'b0001 << req_addr_i[1:0];
                end
                F3_SH: begin
                    fault    = req_addr_i[0];
                    st_wdata = {2{req_wdata_i[15:0]}};
                    st_wstrb = 4'b0011 << req_addr_i[1:0];
                end
                F3_SW: begin
                    fault    = |req_addr_i[1:0];
                    st_wdata = req_wdata_i;
                    st_wstrb = 4'b1111;
                end
                default: fault = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                F3_LB, F3_LBU: fault = 1'b0;
                F3_LH, F3_LHU: fault = req_addr_i[0];
                F3_LW:         fault = |req_addr_i[1:0];
                default:       fault = 1'b1;
            endcase
        end
    end

    assign accept  = req_valid_i && (state == ST_IDLE || state == ST_RESP);
    assign go      = accept && !fault;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nx    = state;
        stall_o     = 1'b0;
        mem_valid_o = 1'b0;
        done_o      = 1'b0;
        wb_valid_o  = 1'b0;
        bus_err_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nx = ST_BUSY;
                    stall_o  = 1'b1;
                end
            end
            ST_BUSY: begin
                mem_valid_o = 1'b1;
                stall_o     = 1'b1;
                // A ready on the expiry cycle still wins over the timeout
                if (mem_ready_i) begin
                    state_nx = ST_RESP;
                end else if (tmo_hit) begin
                    state_nx  = ST_IDLE;
                    bus_err_o = 1'b1;
                end
            end
            ST_RESP: begin
                done_o     = 1'b1;
                wb_valid_o = !store_q;
                if (go) begin
                    state_nx = ST_BUSY;
                    stall_o  = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (mem_rdata_i),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            store_q      <= 1'b0;
            tmo_cnt      <= '0;
            wb_data_q    <= '0;
            misaligned_q <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state        <= state_nx;
            misaligned_q <= accept && fault;
            tmo_cnt      <= (state == ST_BUSY) ? tmo_cnt + 32'd1 : 32'd0;
            if (go) begin
                addr_q  <= req_addr_i;
                f3_q    <= req_funct3_i;
                rd_q    <= req_rd_i;
                store_q <= req_store_i;
                wdata_q <= st_wdata;
                wstrb_q <= st_wstrb;
            end
            if (accept && fault) begin
                fault_addr_q <= req_addr_i;
            end else if (bus_err_o) begin
                fault_addr_q <= addr_q;
            end
            if (state == ST_BUSY && mem_ready_i) begin
                wb_data_q <= ld_data;
            end
        end
    end

    assign mem_addr_o   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata_o  = wdata_q;
    assign mem_wstrb_o  = wstrb_q;
    assign wb_rd_o      = rd_q;
    assign wb_data_o    = wb_data_q;
    assign misaligned_o = misaligned_q;
    assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb/tb_rv32i_lsu.sv - randomized self-checking bench for rv32i_lsu against a schedule-based model
module tb_rv32i_lsu;

    localparam int T    = 8;
    localparam int NCYC = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0, req_store_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0, mem_rdata_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        stall_o, mem_valid_o, wb_valid_o, done_o, misaligned_o, bus_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o, fault_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [4:0]  wb_rd_o;

    rv32i_lsu #(.XLEN(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_store_i(req_store_i), .req_funct3_i(req_funct3_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .stall_o(stall_o), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .done_o(done_o), .misaligned_o(misaligned_o),
        .bus_err_o(bus_err_o), .fault_addr_o(fault_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        bit        stall, mvalid, store, done, wbv, mis, berr, zero;
        bit [31:0] addr, wdata;
        bit [3:0]  wstrb;
        bit [4:0]  rd;
        bit [31:0] wbd;
    } exp_t;

    exp_t        exp_tab[NCYC];
    bit [31:0]   exp_fault[NCYC];
    logic [31:0] mon_addr[NCYC], mon_wdata[NCYC], mon_wstrb[NCYC], mon_done[NCYC], mon_stall[NCYC];
    logic [31:0] mon_valid[NCYC], mon_wbd[NCYC], mon_wbrd[NCYC], mon_mis[NCYC], mon_berr[NCYC], mon_fault[NCYC];
    exp_t        ce;
    bit          chk_en = 1'b0;
    int          n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv, input int at);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, at, act, expv);
        end
    endtask

    // Access size in bytes; 0 marks an illegal funct3
    function automatic int acc_size(input bit st, input bit [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_fault(input bit st, input bit [2:0] f3, input bit [31:0] a);
        int sz;
        sz = acc_size(st, f3);
        return (sz == 0) || ((a % sz) != 0);
    endfunction

    function automatic bit [3:0] m_wstrb(input int sz, input bit [31:0] a);
        int s;
        s = ((1 << sz) - 1) << (a % 4);
        return s[3:0];
    endfunction

    function automatic bit [31:0] m_wdata(input int sz, input bit [31:0] wd);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rw);
        longint unsigned v, lim;
        lim = 64'd1 << (8 * acc_size(1'b0, f3));
        v   = ({32'd0, rw} >> (8 * (a % 4))) % lim;
        if (f3 < 3'd4 && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    task automatic set_fault(input int from, input bit [31:0] v);
        for (int k = from; k < NCYC; k++) exp_fault[k] = v;
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            ce = exp_tab[cyc];
            mon_addr[cyc] = mem_addr_o;    mon_wdata[cyc] = mem_wdata_o;  mon_wstrb[cyc] = 32'(mem_wstrb_o);
            mon_done[cyc] = 32'(done_o);   mon_stall[cyc] = 32'(stall_o); mon_valid[cyc] = 32'(mem_valid_o);
            mon_wbd[cyc]  = wb_data_o;     mon_wbrd[cyc]  = 32'(wb_rd_o); mon_mis[cyc]   = 32'(misaligned_o);
            mon_berr[cyc] = 32'(bus_err_o); mon_fault[cyc] = fault_addr_o;
            chk("stall", 32'(stall_o), 32'(ce.stall), cyc);
            chk("mem_valid", 32'(mem_valid_o), 32'(ce.mvalid), cyc);
            chk("done", 32'(done_o), 32'(ce.done), cyc);
            chk("wb_valid", 32'(wb_valid_o), 32'(ce.wbv), cyc);
            chk("misaligned", 32'(misaligned_o), 32'(ce.mis), cyc);
            chk("bus_err", 32'(bus_err_o), 32'(ce.berr), cyc);
            chk("fault_addr", fault_addr_o, exp_fault[cyc], cyc);
            if (ce.mvalid) begin
                chk("mem_addr", mem_addr_o, ce.addr, cyc);
                chk("mem_wstrb", 32'(mem_wstrb_o), 32'(ce.wstrb), cyc);
                if (ce.store) chk("mem_wdata", mem_wdata_o, ce.wdata, cyc);
            end
            if (ce.wbv) begin
                chk("wb_rd", 32'(wb_rd_o), 32'(ce.rd), cyc);
                chk("wb_data", wb_data_o, ce.wbd, cyc);
            end
            if (ce.zero) begin
                chk("rst_addr", mem_addr_o, 32'd0, cyc);
                chk("rst_wdata", mem_wdata_o, 32'd0, cyc);
                chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0, cyc);
                chk("rst_wb_rd", 32'(wb_rd_o), 32'd0, cyc);
                chk("rst_wb_data", wb_data_o, 32'd0, cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            req_valid_i = 1'b0; req_store_i = 1'($urandom); req_funct3_i = 3'($urandom);
            req_addr_i = $urandom; req_wdata_i = $urandom; req_rd_i = 5'($urandom);
            mem_ready_i = 1'($urandom); mem_rdata_i = $urandom;
            @(posedge clk); #1;
        end
    endtask

    // d = BUSY cycle (1-based) carrying mem_ready_i; 0 or >T means never ready
    task automatic run_txn(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                           input bit [4:0] rd, input int d, input bit [31:0] rw, output int c0);
        int sz, nb;
        bit ok;
        c0 = cyc;
        req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3;
        req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
        mem_ready_i = 1'($urandom); mem_rdata_i = $urandom;
        if (is_fault(st, f3, a)) begin
            exp_tab[c0 + 1].mis = 1'b1;
            set_fault(c0 + 1, a);
            @(posedge clk); #1;
            return;
        end
        sz = acc_size(st, f3);
        ok = (d >= 1 && d <= T);
        nb = ok ? d : T;
        exp_tab[c0].stall = 1'b1;
        for (int i = 1; i <= nb; i++) begin
            exp_tab[c0 + i].stall  = 1'b1;
            exp_tab[c0 + i].mvalid = 1'b1;
            exp_tab[c0 + i].store  = st;
            exp_tab[c0 + i].addr   = a & ~32'd3;
            exp_tab[c0 + i].wstrb  = st ? m_wstrb(sz, a) : 4'd0;
            exp_tab[c0 + i].wdata  = m_wdata(sz, wd);
        end
        if (ok) begin
            exp_tab[c0 + nb + 1].done = 1'b1;
            exp_tab[c0 + nb + 1].wbv  = !st;
            exp_tab[c0 + nb + 1].rd   = rd;
            exp_tab[c0 + nb + 1].wbd  = m_load(f3, a, rw);
        end else begin
            exp_tab[c0 + T].berr = 1'b1;
            set_fault(c0 + T + 1, a);
        end
        for (int i = 1; i <= nb; i++) begin
            @(posedge clk); #1;
            mem_ready_i = (i == d);
            mem_rdata_i = (i == d) ? rw : $urandom;
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_busy();
        int c0;
        c0 = cyc;
        req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'd2;
        req_addr_i = 32'h0000_0400; req_rd_i = 5'd9; mem_ready_i = 1'b0;
        exp_tab[c0].stall = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            exp_tab[c0 + i].stall = 1'b1; exp_tab[c0 + i].mvalid = 1'b1;
            exp_tab[c0 + i].addr  = 32'h0000_0400; exp_tab[c0 + i].wstrb = 4'd0;
        end
        exp_tab[c0 + 3].zero = 1'b1;
        set_fault(c0 + 3, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0; req_valid_i = 1'b0;
        idle(3);
        chk("rst_mid_valid", mon_valid[c0 + 3], 32'd0, c0 + 3);
    endtask

    bit          r_st;
    bit [2:0]    r_f3;
    bit [31:0]   r_a;
    int          r_d, r_sz, c0, c1;
    bit [2:0]    ld_list[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_tab[cyc].zero = 1'b1;
        chk_en = 1'b1;
        idle(2);

        run_txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 2, 32'd0, c0);
        idle(2);
        chk("sw_addr", mon_addr[c0 + 1], 32'h100, c0 + 1);
        chk("sw_wstrb", mon_wstrb[c0 + 1], 32'hF, c0 + 1);
        chk("sw_wdata_hold", mon_wdata[c0 + 2], 32'hDEADBEEF, c0 + 2);
        chk("sw_done", mon_done[c0 + 3], 32'd1, c0 + 3);
        chk("sw_resp_stall", mon_stall[c0 + 3], 32'd0, c0 + 3);

        run_txn(1'b1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 1, 32'd0, c0);
        idle(1);
        chk("sb_addr", mon_addr[c0 + 1], 32'h100, c0 + 1);
        chk("sb_wstrb", mon_wstrb[c0 + 1], 32'h8, c0 + 1);
        chk("sb_wdata", mon_wdata[c0 + 1], 32'hA5A5A5A5, c0 + 1);
        run_txn(1'b1, 3'd1, 32'h102, 32'h00001234, 5'd0, 1, 32'd0, c0);
        idle(1);
        chk("sh_wstrb", mon_wstrb[c0 + 1], 32'hC, c0 + 1);
        chk("sh_wdata", mon_wdata[c0 + 1], 32'h12341234, c0 + 1);

        run_txn(1'b0, 3'd0, 32'h101, 32'd0, 5'd5, 1, 32'h123480FF, c0);
        idle(1);
        chk("lb_data", mon_wbd[c0 + 2], 32'hFFFFFF80, c0 + 2);
        chk("lb_rd", mon_wbrd[c0 + 2], 32'd5, c0 + 2);
        run_txn(1'b0, 3'd4, 32'h101, 32'd0, 5'd6, 1, 32'h123480FF, c0);
        idle(1);
        chk("lbu_data", mon_wbd[c0 + 2], 32'h00000080, c0 + 2);
        run_txn(1'b0, 3'd1, 32'h102, 32'd0, 5'd7, 1, 32'h123480FF, c0);
        idle(1);
        chk("lh_data", mon_wbd[c0 + 2], 32'h00001234, c0 + 2);
        run_txn(1'b0, 3'd2, 32'h100, 32'd0, 5'd31, 1, 32'h123480FF, c0);
        idle(1);
        chk("lw_data", mon_wbd[c0 + 2], 32'h123480FF, c0 + 2);
        chk("lw_rd", mon_wbrd[c0 + 2], 32'd31, c0 + 2);

        run_txn(1'b0, 3'd2, 32'h102, 32'd0, 5'd1, 1, 32'd0, c0);
        idle(1);
        chk("lw_mis", mon_mis[c0 + 1], 32'd1, c0 + 1);
        chk("lw_mis_addr", mon_fault[c0 + 1], 32'h102, c0 + 1);
        run_txn(1'b1, 3'd1, 32'h101, 32'd0, 5'd1, 1, 32'd0, c0);
        idle(1);
        chk("sh_mis_addr", mon_fault[c0 + 1], 32'h101, c0 + 1);
        run_txn(1'b0, 3'd3, 32'h300, 32'd0, 5'd1, 1, 32'd0, c0);
        idle(1);
        chk("ld_f3_3_mis", mon_mis[c0 + 1], 32'd1, c0 + 1);

        run_txn(1'b0, 3'd2, 32'h200, 32'd0, 5'd2, 0, 32'd0, c0);
        idle(1);
        chk("tmo_err", mon_berr[c0 + T], 32'd1, c0 + T);
        chk("tmo_valid_drop", mon_valid[c0 + T + 1], 32'd0, c0 + T + 1);
        chk("tmo_fault_addr", mon_fault[c0 + T + 1], 32'h200, c0 + T + 1);

        run_txn(1'b0, 3'd2, 32'h204, 32'd0, 5'd3, T, 32'hCAFEF00D, c0);
        idle(1);
        chk("tmo_tie_no_err", mon_berr[c0 + T], 32'd0, c0 + T);

        reset_mid_busy();

        run_txn(1'b1, 3'd2, 32'h140, 32'h01020304, 5'd0, 1, 32'd0, c0);
        run_txn(1'b0, 3'd2, 32'h144, 32'd0, 5'd4, 1, 32'h55AA55AA, c1);
        idle(1);
        chk("b2b_stall", mon_stall[c1], 32'd1, c1);
        chk("b2b_valid", mon_valid[c1 + 1], 32'd1, c1 + 1);

        for (int n = 0; n < 250; n++) begin
            r_st = 1'($urandom);
            if ($urandom % 10 < 8) r_f3 = r_st ? 3'($urandom % 3) : ld_list[$urandom % 5];
            else r_f3 = 3'($urandom);
            r_a  = $urandom;
            r_sz = acc_size(r_st, r_f3);
            if (r_sz != 0 && $urandom % 3 != 0) r_a = r_a & ~32'(r_sz - 1);
            r_d = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, T));
            run_txn(r_st, r_f3, r_a, $urandom, 5'($urandom), r_d, $urandom, c0);
            if ($urandom % 2 != 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
